// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl -- multi-cycle issue controller for a 32-bit combinational ALU.
//
// Accepts MIPS R-type operations on a valid/ready request channel, decodes
// funct into the ALU select, sequences the external ALU (single pass, or a
// 32-iteration shift-add unsigned multiply) and returns result and flags on a
// valid/ready response channel.
//
// Ports:
//   clk, reset                 clock (rising edge), async active-high reset
//   req_valid/req_ready        request handshake
//   req_funct, req_a, req_b    funct code, operand A (rs), operand B (rt)
//   alu_in1/alu_in2/alu_sel    ALU operand and select drive
//   alu_cin                    ALU carry-in (always 0)
//   alu_result/alu_cout_*      ALU result and adder/subtractor carry-outs
//   rsp_valid/rsp_ready        response handshake
//   rsp_hi/rsp_lo              product high / result or product low
//   rsp_zero/rsp_carry/rsp_err zero, carry and unsupported-funct flags
//
// Configuration macro: ALU_ISSUE_MULTU_EN enables multu (funct 0x19) with the
// MUL state and iteration counter; without it 0x19 reports rsp_err.
module alu_issue_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_funct,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  output logic [3:0]  alu_sel,
  output logic        alu_cin,
  input  logic [31:0] alu_result,
  input  logic        alu_cout_add,
  input  logic        alu_cout_sub,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_hi,
  output logic [31:0] rsp_lo,
  output logic        rsp_zero,
  output logic        rsp_carry,
  output logic        rsp_err
);

  typedef enum logic [3:0] {
    ALU_AND = 4'd0, ALU_OR  = 4'd1, ALU_ADD = 4'd2, ALU_XOR = 4'd3,
    ALU_SUB = 4'd4, ALU_SRA = 4'd5, ALU_SLL = 4'd6, ALU_NOR = 4'd7
  } alu_op_e;

  typedef enum logic [2:0] {
    K_BAD, K_PLAIN, K_ADD, K_SUB, K_SLT, K_SHIFT, K_MUL
  } kind_e;

`ifdef ALU_ISSUE_MULTU_EN
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_RESP} state_e;
`else
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_e;
`endif

  function automatic kind_e dec_kind(input logic [5:0] f);
    case (f)
      6'h20, 6'h21:                      dec_kind = K_ADD;
      6'h22, 6'h23:                      dec_kind = K_SUB;
      6'h24, 6'h25, 6'h26, 6'h27:        dec_kind = K_PLAIN;
      6'h04, 6'h07:                      dec_kind = K_SHIFT;
      6'h2A:                             dec_kind = K_SLT;
`ifdef ALU_ISSUE_MULTU_EN
      6'h19:                             dec_kind = K_MUL;
`endif
      default:                           dec_kind = K_BAD;
    endcase
  endfunction

  function automatic alu_op_e dec_sel(input logic [5:0] f);
    case (f)
      6'h20, 6'h21: dec_sel = ALU_ADD;
      6'h22, 6'h23: dec_sel = ALU_SUB;
      6'h24:        dec_sel = ALU_AND;
      6'h25:        dec_sel = ALU_OR;
      6'h26:        dec_sel = ALU_XOR;
      6'h27:        dec_sel = ALU_NOR;
      6'h04:        dec_sel = ALU_SLL;
      6'h07:        dec_sel = ALU_SRA;
      6'h2A:        dec_sel = ALU_SUB;
      default:      dec_sel = ALU_AND;
    endcase
  endfunction

  state_e      state_q;
  logic [5:0]  funct_q;
  logic [31:0] a_q, b_q;
  logic [31:0] lo_q;          // also the low half of the multiply accumulator
  logic        zero_q, carry_q, err_q, valid_q, ready_q;
  kind_e       req_kind, cur_kind;
  logic [31:0] exec_lo;
  logic        exec_carry;

`ifdef ALU_ISSUE_MULTU_EN
  logic [31:0] hi_q;          // also the high half of the multiply accumulator
  logic [4:0]  cnt_q;
  logic [63:0] mul_d;
  // Shift-add step: add A into hi when the current multiplier bit is set,
  // then shift {carry, sum, lo} right by one.
  assign mul_d  = {alu_cout_add, alu_result, lo_q[31:1]};
  assign rsp_hi = hi_q;
`else
  assign rsp_hi = '0;
`endif

  assign req_kind = dec_kind(req_funct);
  assign cur_kind = dec_kind(funct_q);

  // slt resolves the sign-differs case from the operands, otherwise the
  // sign of A-B decides.
  always_comb begin
    exec_lo = alu_result;
    if (cur_kind == K_SLT)
      exec_lo = {31'b0, (a_q[31] ^ b_q[31]) ? a_q[31] : alu_result[31]};
    case (cur_kind)
      K_ADD:   exec_carry = alu_cout_add;
      K_SUB:   exec_carry = alu_cout_sub;
      default: exec_carry = 1'b0;
    endcase
  end

  always_comb begin
    alu_sel = ALU_AND;
    alu_in1 = a_q;
    alu_in2 = b_q;
    case (state_q)
      S_EXEC: begin
        alu_sel = dec_sel(funct_q);
        if (cur_kind == K_SHIFT) alu_in2 = {27'b0, b_q[4:0]};
      end
`ifdef ALU_ISSUE_MULTU_EN
      S_MUL: begin
        alu_sel = ALU_ADD;
        alu_in1 = hi_q;
        alu_in2 = lo_q[0] ? a_q : '0;
      end
`endif
      default: ;
    endcase
  end

  assign alu_cin   = 1'b0;
  assign req_ready = ready_q;
  assign rsp_valid = valid_q;
  assign rsp_lo    = lo_q;
  assign rsp_zero  = zero_q;
  assign rsp_carry = carry_q;
  assign rsp_err   = err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      funct_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      lo_q    <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
`ifdef ALU_ISSUE_MULTU_EN
      hi_q    <= '0;
      cnt_q   <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid && ready_q) begin
            funct_q <= req_funct;
            a_q     <= req_a;
            b_q     <= req_b;
            ready_q <= 1'b0;
            if (req_kind == K_BAD) begin
              lo_q    <= '0;
              zero_q  <= 1'b1;
              carry_q <= 1'b0;
              err_q   <= 1'b1;
              valid_q <= 1'b1;
`ifdef ALU_ISSUE_MULTU_EN
              hi_q    <= '0;
`endif
              state_q <= S_RESP;
`ifdef ALU_ISSUE_MULTU_EN
            end else if (req_kind == K_MUL) begin
              hi_q    <= '0;
              lo_q    <= req_b;
              cnt_q   <= '0;
              state_q <= S_MUL;
`endif
            end else begin
              state_q <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          lo_q    <= exec_lo;
          zero_q  <= (exec_lo == '0);
          carry_q <= exec_carry;
          err_q   <= 1'b0;
          valid_q <= 1'b1;
`ifdef ALU_ISSUE_MULTU_EN
          hi_q    <= '0;
`endif
          state_q <= S_RESP;
        end
`ifdef ALU_ISSUE_MULTU_EN
        S_MUL: begin
          {hi_q, lo_q} <= mul_d;
          cnt_q        <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            zero_q  <= (mul_d == '0);
            carry_q <= 1'b0;
            err_q   <= 1'b0;
            valid_q <= 1'b1;
            state_q <= S_RESP;
          end
        end
`endif
        S_RESP: begin
          if (rsp_ready) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: models the external ALU, drives requests, pushes
// expected responses into a scoreboard queue and compares them on response.
module tb_alu_issue_ctrl;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_funct;
  logic [31:0] req_a, req_b;
  logic [31:0] alu_in1, alu_in2;
  logic [3:0]  alu_sel;
  logic        alu_cin;
  logic [31:0] alu_result;
  logic        alu_cout_add, alu_cout_sub;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_hi, rsp_lo;
  logic        rsp_zero, rsp_carry, rsp_err;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  alu_issue_ctrl dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct(req_funct),
    .req_a(req_a), .req_b(req_b),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_sel(alu_sel), .alu_cin(alu_cin),
    .alu_result(alu_result), .alu_cout_add(alu_cout_add), .alu_cout_sub(alu_cout_sub),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_hi(rsp_hi), .rsp_lo(rsp_lo), .rsp_zero(rsp_zero),
    .rsp_carry(rsp_carry), .rsp_err(rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External combinational ALU.
  logic [32:0] add_s, sub_s;
  assign add_s = {1'b0, alu_in1} + {1'b0, alu_in2} + {32'b0, alu_cin};
  assign sub_s = {1'b0, alu_in1} + {1'b0, ~alu_in2} + 33'd1;
  assign alu_cout_add = add_s[32];
  assign alu_cout_sub = sub_s[32];
  always_comb begin
    case (alu_sel)
      4'd0:    alu_result = alu_in1 & alu_in2;
      4'd1:    alu_result = alu_in1 | alu_in2;
      4'd2:    alu_result = add_s[31:0];
      4'd3:    alu_result = alu_in1 ^ alu_in2;
      4'd4:    alu_result = sub_s[31:0];
      4'd5:    alu_result = $signed(alu_in1) >>> alu_in2[4:0];
      4'd6:    alu_result = alu_in1 << alu_in2[4:0];
      4'd7:    alu_result = ~(alu_in1 | alu_in2);
      default: alu_result = '0;
    endcase
  end

  typedef struct {
    logic [31:0] hi, lo;
    logic        zero, carry, err;
    int unsigned lat;
    logic [3:0]  sel;
    logic [31:0] in2;
  } exp_t;

  exp_t sb[$];

  function automatic exp_t model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [32:0] s;
    logic [63:0] p;
    e.hi = '0; e.lo = '0; e.carry = 1'b0; e.err = 1'b0;
    e.lat = 2; e.sel = 4'd0; e.in2 = b;
    case (f)
      6'h20, 6'h21: begin s = {1'b0, a} + {1'b0, b}; e.lo = s[31:0]; e.carry = s[32]; e.sel = 4'd2; end
      6'h22, 6'h23: begin e.lo = a - b; e.carry = (a >= b); e.sel = 4'd4; end
      6'h24: begin e.lo = a & b;    e.sel = 4'd0; end
      6'h25: begin e.lo = a | b;    e.sel = 4'd1; end
      6'h26: begin e.lo = a ^ b;    e.sel = 4'd3; end
      6'h27: begin e.lo = ~(a | b); e.sel = 4'd7; end
      6'h04: begin e.lo = a << b[4:0]; e.sel = 4'd6; e.in2 = {27'b0, b[4:0]}; end
      6'h07: begin e.lo = $signed(a) >>> b[4:0]; e.sel = 4'd5; e.in2 = {27'b0, b[4:0]}; end
      6'h2A: begin e.lo = {31'b0, ($signed(a) < $signed(b))}; e.sel = 4'd4; end
`ifdef ALU_ISSUE_MULTU_EN
      6'h19: begin
        p = {32'b0, a} * {32'b0, b};
        e.hi = p[63:32]; e.lo = p[31:0]; e.lat = 33; e.sel = 4'd2;
        e.in2 = b[0] ? a : 32'd0;
      end
`endif
      default: begin e.err = 1'b1; e.lat = 1; end
    endcase
    e.zero = ({e.hi, e.lo} == 64'd0);
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one request, measure latency, optionally stall the response for
  // 'hold' cycles (poking a second request if 'poke'), then complete it.
  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        input int unsigned hold, input logic poke);
    exp_t e, r;
    int unsigned edges;
    @(negedge clk);
    check("req_ready_idle", 64'(req_ready), 64'd1);
    e = model(f, a, b);
    sb.push_back(e);
    req_valid = 1'b1; req_funct = f; req_a = a; req_b = b;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    req_valid = 1'b0;
    check("alu_sel", 64'(alu_sel), 64'(e.sel));
    check("alu_in2", 64'(alu_in2), 64'(e.in2));
    while (!rsp_valid && edges < 64) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    check("latency", 64'(edges), 64'(e.lat));
    for (int unsigned i = 0; i < hold; i++) begin
      if (poke) begin req_valid = 1'b1; req_funct = 6'h21; req_a = 32'd5; req_b = 32'd6; end
      @(posedge clk);
      @(negedge clk);
      check("hold_valid", 64'(rsp_valid), 64'd1);
      check("hold_lo", 64'(rsp_lo), 64'(e.lo));
      check("hold_err", 64'(rsp_err), 64'(e.err));
      check("hold_req_ready", 64'(req_ready), 64'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    r = sb.pop_front();
    check("rsp_hi", 64'(rsp_hi), 64'(r.hi));
    check("rsp_lo", 64'(rsp_lo), 64'(r.lo));
    check("rsp_zero", 64'(rsp_zero), 64'(r.zero));
    check("rsp_carry", 64'(rsp_carry), 64'(r.carry));
    check("rsp_err", 64'(rsp_err), 64'(r.err));
    check("busy_req_ready", 64'(req_ready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check("post_rsp_valid", 64'(rsp_valid), 64'd0);
    check("post_req_ready", 64'(req_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_funct = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_rsp_lo", 64'(rsp_lo), 64'd0);
    check("rst_rsp_hi", 64'(rsp_hi), 64'd0);
    check("rst_alu_in1", 64'(alu_in1), 64'd0);
    check("rst_alu_sel", 64'(alu_sel), 64'd0);
    check("rst_alu_cin", 64'(alu_cin), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    run_op(6'h21, 32'hFFFF_FFFF, 32'h0000_0002, 0, 1'b0);  // addu wrap, carry
    run_op(6'h20, 32'h7FFF_FFFF, 32'h0000_0001, 0, 1'b0);  // add, no carry
    run_op(6'h2A, 32'hFFFF_FFFE, 32'h0000_0001, 0, 1'b0);  // slt negative < positive
    run_op(6'h2A, 32'h0000_0001, 32'hFFFF_FFFE, 0, 1'b0);  // slt positive > negative
    run_op(6'h2A, 32'h0000_0003, 32'h0000_0009, 0, 1'b0);  // slt same sign
    run_op(6'h22, 32'h0000_1234, 32'h0000_1234, 0, 1'b0);  // sub to zero
    run_op(6'h23, 32'h0000_0000, 32'h0000_0001, 0, 1'b0);  // subu borrow
    run_op(6'h07, 32'h8000_0000, 32'h0000_0024, 0, 1'b0);  // srav masks amount
    run_op(6'h04, 32'h0000_0001, 32'h0000_001F, 0, 1'b0);  // sllv by 31
    run_op(6'h24, 32'hF0F0_1234, 32'h0FF0_FFFF, 0, 1'b0);
    run_op(6'h25, 32'hF000_0000, 32'h0000_000F, 0, 1'b0);
    run_op(6'h26, 32'hAAAA_5555, 32'hFFFF_0000, 0, 1'b0);
    run_op(6'h27, 32'h0000_0000, 32'h0000_0000, 0, 1'b0);
    run_op(6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 1'b0);  // multu max
    run_op(6'h19, 32'h0001_2345, 32'h0000_1000, 0, 1'b0);
    run_op(6'h3F, 32'h1234_5678, 32'h9ABC_DEF0, 5, 1'b1);  // unsupported, stalled

    // Reset in the middle of a long operation discards it.
    @(negedge clk);
    req_valid = 1'b1; req_funct = 6'h19; req_a = 32'hFFFF_FFFF; req_b = 32'hFFFF_FFFF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("midrst_req_ready", 64'(req_ready), 64'd1);
    check("midrst_alu_sel", 64'(alu_sel), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    run_op(6'h21, 32'd3, 32'd4, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
